// File: rtl/sad_me_ctrl.sv
// Sequencing controller for a 2x2 SAD motion-estimation datapath.
// Walks NCAND candidates, accumulates partial SADs, tracks the minimum.
module sad_me_ctrl #(
  parameter int NCAND = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [7:0]  req_cand,
  output logic [2:0]  req_row,
  output logic [2:0]  req_col,
  input  logic        sad_valid,
  input  logic [9:0]  sad_in,
  output logic        done,
  output logic [13:0] best_sad,
  output logic [7:0]  best_idx
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [11:0] LAST = 12'(NCAND * 16 - 1);

  state_t      state;
  state_t      state_nx;
  logic [11:0] req_cnt;
  logic [11:0] rsp_cnt;
  logic        rsp_all;
  logic [13:0] acc;
  logic [13:0] total;
  logic        xfer;
  logic        rsp_en;
  logic        rsp_last;

  // Request fields decode straight from the raster counter.
  assign req_cand = req_cnt[11:4];
  assign req_row  = {req_cnt[3:2], 1'b0};
  assign req_col  = {req_cnt[1:0], 1'b0};

  assign xfer     = req_valid && req_ready;
  assign rsp_en   = sad_valid && !rsp_all &&
                    (state == RUN || state == DRAIN);
  assign rsp_last = rsp_en && (rsp_cnt == LAST);
  assign total    = acc + {4'd0, sad_in};

  always_comb begin
    state_nx  = state;
    req_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = RUN;
      end
      RUN: begin
        req_valid = 1'b1;
        if (xfer && req_cnt == LAST) state_nx = DRAIN;
      end
      DRAIN: begin
        if (rsp_all || rsp_last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_cnt  <= '0;
      rsp_cnt  <= '0;
      rsp_all  <= 1'b0;
      acc      <= '0;
      best_sad <= 14'h3FFF;
      best_idx <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        req_cnt  <= '0;
        rsp_cnt  <= '0;
        rsp_all  <= 1'b0;
        acc      <= '0;
        best_sad <= 14'h3FFF;
        best_idx <= '0;
      end else begin
        if (xfer) req_cnt <= req_cnt + 12'd1;
        if (rsp_en) begin
          rsp_cnt <= rsp_cnt + 12'd1;
          if (rsp_last) rsp_all <= 1'b1;
          // Sixteenth sub-block closes the candidate; strict < keeps lower index on ties.
          if (rsp_cnt[3:0] == 4'hF) begin
            acc <= '0;
            if (total < best_sad) begin
              best_sad <= total;
              best_idx <= rsp_cnt[11:4];
            end
          end else begin
            acc <= total;
          end
        end
      end
    end
  end

endmodule

// File: doc/sad_me_ctrl.md
# sad_me_ctrl

Sequencing controller for the 2x2 SAD datapath in a block-matching motion-estimation path. For one 8x8 current block it walks NCAND candidate blocks. Each candidate is split into 16 2x2 sub-blocks, and the controller issues one fetch request per sub-block to the pixel memories, which feed the SAD unit. It accumulates the returned 10-bit partial SADs per candidate and reports the minimum total SAD and the index of the candidate that produced it.

## Interface
Parameters:
- NCAND, 16: number of candidates per search. Legal range 1..256.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a search. Honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- req_valid  out  1  a fetch request is presented.
- req_ready  in  1  the memory accepts the request. Transfer occurs when req_valid && req_ready.
- req_cand  out  8  candidate index of the current request.
- req_row  out  3  pixel row of the 2x2 top-left corner. Always even.
- req_col  out  3  pixel column of the 2x2 top-left corner. Always even.
- sad_valid  in  1  sad_in carries the partial SAD for the oldest outstanding request. Responses return in request order with latency >= 1 cycle.
- sad_in  in  10  partial 2x2 SAD, 0..1020.
- done  out  1  one-cycle pulse; best_sad and best_idx are valid.
- best_sad  out  14  minimum 8x8 SAD, 0..16320.
- best_idx  out  8  candidate index that achieved best_sad.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: req_valid=0 and busy=0.
  - start=1 → RUN. This clears the request counter, the response counter and the accumulator, and sets the best register to 14'h3FFF.
- RUN: req_valid=1.
  - Request order is raster within each candidate: col 0,2,4,6, then row += 2. Candidates follow in ascending order from 0.
  - The fields advance only on a transfer.
  - After the transfer of (cand=NCAND-1, row=6, col=6) → DRAIN.
- DRAIN: req_valid=0. Wait until NCAND*16 responses have been received → DONE.
- Responses are counted in RUN and DRAIN, independent of request state.
  - Each sad_valid adds sad_in into a 14-bit accumulator.
  - The 16th response of a candidate compares the total (acc + sad_in) with best.
  - If the total is strictly less than best, best_sad and best_idx are updated. Ties keep the lower index.
  - The accumulator then clears for the next candidate in the same cycle.
- DONE: done=1 for exactly one cycle, then → IDLE. best_sad and best_idx hold until the next accepted start.
- sad_valid is ignored in IDLE and DONE, and beyond the NCAND*16th response.
- start is ignored while busy=1. A start in the DONE cycle is ignored.
- Arithmetic:
  - Unsigned throughout.
  - 16 × 1020 = 16320 fits in 14 bits, so no saturation is required.
  - The request counter is 12 bits, the response counter is 12 bits.
- Reset, asynchronous, is effective at any time including mid-search:
  - state=IDLE, busy=0, req_valid=0, done=0.
  - req_cand=0, req_row=0, req_col=0.
  - best_sad=14'h3FFF, best_idx=0, accumulator=0.
  - Responses still in flight after reset are ignored, because the block is in IDLE.

## Timing
- start sampled high in cycle 0: busy=1 and req_valid=1 from cycle 1.
- With req_ready held at 1, one request transfers per cycle. The last request transfers in cycle NCAND*16.
- The best register updates on the clock edge of the 16th response of each candidate.
  - Result visible on the following cycle.
- done is asserted the cycle after the final response is sampled. busy falls together with done's deassertion.
- With req_ready low, req_valid, req_cand, req_row and req_col must stay stable until the transfer.
- Simultaneous transfer and response in the same cycle are both processed.
- A response may arrive in the same cycle as the last request transfer.
- With fixed response latency L and req_ready=1 throughout, done occurs at cycle NCAND*16 + L + 1 after start.

## Test plan
- Basic search:
  - Stimulus: NCAND=4, req_ready=1, latency 1. Candidate c returns sad_in = 100-10*c on every sub-block.
  - Required: totals 1600/1440/1280/1120. done with best_sad=1120, best_idx=3, at cycle 66 after start.
- Tie-break:
  - Stimulus: candidates 1 and 2 both total 500, others 900.
  - Required: best_idx=1, best_sad=500.
- Backpressure:
  - Stimulus: req_ready toggles 1,0,0,1 repeatedly.
  - Required: request fields hold while ready=0. Request sequence is cand0 (0,0),(0,2),(0,4),(0,6),(2,0)… with no skipped or repeated requests. Result is identical to the unstalled run.
- Maximum values:
  - Stimulus: every sad_in=1020, NCAND=1.
  - Required: best_sad=16320, best_idx=0, no overflow.
- Protocol edges:
  - Stimulus: start pulsed during RUN and again in the DONE cycle. Extra sad_valid pulses are sent after the last expected response.
  - Required: neither start nor the extra sad_valid pulses have any effect. done pulses once.
- Reset mid-search:
  - Stimulus: assert rst in RUN after 20 transfers, while responses are still arriving.
  - Required: immediately busy=0, req_valid=0, best_sad=14'h3FFF. A new start then yields correct results.
